// File: rtl/tap_period_decoder.sv
// Measures the rising-to-rising period of a blinking divider tap and decodes which tap drove it.
// Build option: define TAP_CONFIRM_EN to require two consecutive matching measurements before committing.
module tap_period_decoder #(
  parameter int WIDTH   = 8,
  parameter int LOW_TAP = 4,
  parameter int TOL     = 2,
  parameter int CNT_W   = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic             tap_valid,
  output logic [1:0]       tap_idx,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             err,
  output logic             timeout,
  output logic             dbg_state
);

  // Handshake: tap_valid, err and timeout are single-cycle pulses with no backpressure;
  // tap_idx, period and locked are levels that hold until the next measurement or timeout.

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

  state_t           state_q, state_d;
  logic             sync0_q, sync1_q, prev_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [1:0]       tap_idx_q, tap_idx_d;
  logic             locked_q, locked_d;
  logic             tap_valid_q, tap_valid_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
`ifdef TAP_CONFIRM_EN
  logic [1:0]       cand_idx_q, cand_idx_d;
  logic             cand_ok_q, cand_ok_d;
`endif

  logic signed [CNT_W:0] diff [4];
  logic [3:0]            hit;
  logic                  match;
  logic [1:0]            match_idx;

  assign rise = sync1_q & ~prev_q;

  // Signed distance of the running count from each tap's nominal period.
  for (genvar n = 0; n < 4; n++) begin : g_cls
    localparam int NOM = 1 << (LOW_TAP + n + 1);
    assign diff[n] = $signed({1'b0, cnt_q}) - $signed((CNT_W+1)'(NOM));
    assign hit[n]  = (diff[n] <= TOL_S) && (diff[n] >= -TOL_S);
  end

  always_comb begin
    match     = |hit;
    match_idx = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (hit[n]) match_idx = 2'(n);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    tap_idx_d   = tap_idx_q;
    locked_d    = locked_q;
    tap_valid_d = 1'b0;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
`ifdef TAP_CONFIRM_EN
    cand_idx_d  = cand_idx_q;
    cand_ok_d   = cand_ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // A rise wins over timeout even when the count sits at all-ones.
        if (rise) begin
          period_d = cnt_q;
          cnt_d    = CNT_W'(1);
          if (match) begin
`ifdef TAP_CONFIRM_EN
            if (cand_ok_q && (cand_idx_q == match_idx)) begin
              tap_idx_d   = match_idx;
              locked_d    = 1'b1;
              tap_valid_d = 1'b1;
            end else begin
              cand_idx_d = match_idx;
              cand_ok_d  = 1'b1;
            end
`else
            tap_idx_d   = match_idx;
            locked_d    = 1'b1;
            tap_valid_d = 1'b1;
`endif
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
`ifdef TAP_CONFIRM_EN
            cand_ok_d = 1'b0;
`endif
          end
        end else if (cnt_q == '1) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = IDLE;
`ifdef TAP_CONFIRM_EN
          cand_ok_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sync0_q     <= 1'b0;
      sync1_q     <= 1'b0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      tap_idx_q   <= 2'd0;
      locked_q    <= 1'b0;
      tap_valid_q <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef TAP_CONFIRM_EN
      cand_idx_q  <= 2'd0;
      cand_ok_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync0_q     <= sig_in;
      sync1_q     <= sync0_q;
      prev_q      <= sync1_q;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      tap_idx_q   <= tap_idx_d;
      locked_q    <= locked_d;
      tap_valid_q <= tap_valid_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
`ifdef TAP_CONFIRM_EN
      cand_idx_q  <= cand_idx_d;
      cand_ok_q   <= cand_ok_d;
`endif
    end
  end

  assign tap_valid = tap_valid_q;
  assign tap_idx   = tap_idx_q;
  assign period    = period_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tap_period_decoder.sv
// Scoreboarded bench for tap_period_decoder: directed square waves with hand-computed tap results.
module tb_tap_period_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sig_in = 1'b0;
  logic       tap_valid, locked, err, timeout, dbg_state;
  logic [1:0] tap_idx;
  logic [8:0] period;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // {cycle[31:0], tap_valid, err, timeout, tap_idx[1:0], period[8:0], locked}
  logic [46:0] exp_q[$];

  // model state
  bit         in_meas = 0;
  int         last_c = 0;
  bit         wave_match = 0;
  logic [1:0] wave_idx = 2'd0;
  logic [1:0] exp_tap = 2'd0;
  logic [8:0] exp_period = 9'd0;
  bit         exp_locked = 0;
  bit         cand_ok = 0;
  logic [1:0] cand = 2'd0;

  tap_period_decoder dut (
    .clk(clk), .reset(reset), .sig_in(sig_in),
    .tap_valid(tap_valid), .tap_idx(tap_idx), .period(period),
    .locked(locked), .err(err), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_evt(input int c, input bit tv, input bit er, input bit to);
    exp_q.push_back({32'(c), tv, er, to, exp_tap, exp_period, exp_locked});
  endtask

  task automatic on_rise(input int c);
    if (!in_meas) begin
      in_meas = 1;
      last_c  = c;
    end else begin
      exp_period = 9'(c - last_c);
      last_c     = c;
      if (wave_match) begin
`ifdef TAP_CONFIRM_EN
        if (cand_ok && cand == wave_idx) begin
          exp_tap = wave_idx; exp_locked = 1; push_evt(c + 3, 1, 0, 0);
        end else begin
          cand = wave_idx; cand_ok = 1;
        end
`else
        exp_tap = wave_idx; exp_locked = 1; push_evt(c + 3, 1, 0, 0);
`endif
      end else begin
        exp_locked = 0; cand_ok = 0; push_evt(c + 3, 0, 1, 0);
      end
    end
  endtask

  // n rising edges of a period-p square wave; m/idx = hand-computed classification of p
  task automatic stream(input int p, input int n, input bit m, input logic [1:0] idx);
    for (int r = 0; r < n; r++) begin
      sig_in = 1'b1;
      on_rise(cyc);
      wave_match = m;
      wave_idx   = idx;
      repeat (p / 2) @(negedge clk);
      sig_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  task automatic wait_timeout();
    int tc;
    tc = last_c + 514;
    exp_locked = 0;
    push_evt(tc, 0, 0, 1);
    in_meas = 0; cand_ok = 0;
    while (cyc < tc + 2) @(negedge clk);
    chk("idle_after_timeout", 32'(dbg_state), 32'd0);
  endtask

  task automatic do_reset(input int ncyc, input bit toggle);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk); guard++;
    end
    chk("pending_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    reset = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (toggle) sig_in = ~sig_in;
      @(negedge clk);
    end
    chk("rst_tap_valid", 32'(tap_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_tap_idx", 32'(tap_idx), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    sig_in = 1'b0;
    reset  = 1'b0;
    in_meas = 0; exp_tap = 2'd0; exp_period = 9'd0; exp_locked = 0; cand_ok = 0;
    repeat (4) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [46:0] e, a;
    if (tap_valid === 1'b1 || err === 1'b1 || timeout === 1'b1) begin
      checks++;
      a = {32'(cyc), tap_valid, err, timeout, tap_idx, period, locked};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d tv=%b err=%b to=%b idx=%0d period=%0d",
                 cyc, tap_valid, err, timeout, tap_idx, period);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL pulse actual cyc=%0d tv/err/to=%b%b%b idx=%0d period=%0d locked=%b expected cyc=%0d tv/err/to=%b%b%b idx=%0d period=%0d locked=%b",
                   a[46:15], a[14], a[13], a[12], a[11:10], a[9:1], a[0],
                   e[46:15], e[14], e[13], e[12], e[11:10], e[9:1], e[0]);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset(3, 1);

    // main decode across taps and a tap switch
    stream(32, 3, 1, 2'd0);
    stream(256, 3, 1, 2'd3);
    stream(64, 3, 1, 2'd1);
    stream(100, 3, 0, 2'd0);
    stream(33, 3, 1, 2'd0);
    wait_timeout();

    // tolerance boundaries and the all-ones count edge case
    stream(30, 2, 1, 2'd0);
    stream(34, 2, 1, 2'd0);
    stream(35, 2, 0, 2'd0);
    stream(126, 2, 1, 2'd2);
    stream(130, 2, 1, 2'd2);
    stream(131, 2, 0, 2'd0);
    stream(511, 2, 0, 2'd0);
    stream(32, 2, 1, 2'd0);
    wait_timeout();

    stream(128, 4, 1, 2'd2);
    wait_timeout();

    // reset in the middle of a stream, then relock
    stream(32, 3, 1, 2'd0);
    repeat (10) @(negedge clk);
    do_reset(2, 0);
    stream(32, 3, 1, 2'd0);
    wait_timeout();

    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
